// File: rtl/adder_mw_seq.sv
// Multi-word add/subtract sequencer chaining one shared 32-bit CLA across NUM_WORDS beats, LS word first.
// Optional: define ADDER_MW_SEQ_OVF_EN to enable signed-overflow detection on the top word.

module adder_cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [8:0]  gc;

  assign g     = a & b;
  assign p     = a ^ b;
  assign gc[0] = cin;
  assign cout  = gc[8];

  // Full lookahead inside each nibble; group generate/propagate chain the nibbles.
  for (genvar k = 0; k < 8; k++) begin : g_grp
    logic [3:0] gg;
    logic [3:0] pp;
    logic [3:0] c;

    assign gg   = g[4*k +: 4];
    assign pp   = p[4*k +: 4];
    assign c[0] = gc[k];
    assign c[1] = gg[0] | (pp[0] & gc[k]);
    assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gc[k]);
    assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                | (pp[2] & pp[1] & pp[0] & gc[k]);
    assign gc[k+1] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                   | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & gc[k]);
    assign sum[4*k +: 4] = pp ^ c;
  end

endmodule

module adder_mw_seq #(
  parameter int NUM_WORDS = 4,
  parameter int CNT_W     = $clog2(NUM_WORDS)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_sub,
  input  logic        i_Cin,
  input  logic        i_vld,
  output logic        o_rdy,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  output logic [31:0] o_S,
  output logic        o_S_vld,
  output logic        o_Cout,
  output logic        o_ovf,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               carry_q;
  logic               sub_q;
  logic               beat;
  logic               last_beat;
  logic               start_ok;
  logic [31:0]        b_eff;
  logic [31:0]        add_sum;
  logic               add_cout;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  assign o_rdy     = (state == RUN);
  assign o_done    = (state == DONE);
  assign o_busy    = (state != IDLE);
  assign beat      = i_vld & o_rdy;
  assign last_beat = beat & (cnt == LAST_CNT);
  assign start_ok  = (state == IDLE) & i_start;
  assign b_eff     = sub_q ? ~i_B : i_B;

  adder_cla32 u_cla (
    .a    (i_A),
    .b    (b_eff),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start)   next_state = RUN;
      RUN:     if (last_beat) next_state = DONE;
      DONE:                   next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so the carry register seeds with 1 in sub mode.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      o_S     <= '0;
      o_S_vld <= 1'b0;
      o_Cout  <= 1'b0;
    end else begin
      o_S_vld <= beat;
      if (start_ok) begin
        sub_q   <= i_sub;
        carry_q <= i_sub | i_Cin;
        cnt     <= '0;
        o_Cout  <= 1'b0;
      end else if (beat) begin
        o_S     <= add_sum;
        carry_q <= add_cout;
        if (last_beat) begin
          cnt    <= '0;
          o_Cout <= add_cout;
        end else begin
          cnt    <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef ADDER_MW_SEQ_OVF_EN
  // Carry into bit 31 is recovered from the sum bit, so the adder needs no extra tap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          o_ovf <= 1'b0;
    else if (start_ok)  o_ovf <= 1'b0;
    else if (last_beat) o_ovf <= i_A[31] ^ b_eff[31] ^ add_sum[31] ^ add_cout;
  end
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_mw_seq.sv
// Directed self-checking bench for adder_mw_seq (NUM_WORDS = 4).

module tb_adder_mw_seq;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        i_sub;
  logic        i_Cin;
  logic        i_vld;
  logic        o_rdy;
  logic [31:0] i_A;
  logic [31:0] i_B;
  logic [31:0] o_S;
  logic        o_S_vld;
  logic        o_Cout;
  logic        o_ovf;
  logic        o_busy;
  logic        o_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] opa   [4];
  logic [31:0] opb   [4];
  logic [31:0] exp_w [4];
  logic [31:0] got_words [$];
  int          done_count;
  int          done_with_vld;

  adder_mw_seq #(.NUM_WORDS(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (i_start),
    .i_sub   (i_sub),
    .i_Cin   (i_Cin),
    .i_vld   (i_vld),
    .o_rdy   (o_rdy),
    .i_A     (i_A),
    .i_B     (i_B),
    .o_S     (o_S),
    .o_S_vld (o_S_vld),
    .o_Cout  (o_Cout),
    .o_ovf   (o_ovf),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_S_vld) got_words.push_back(o_S);
      if (o_done) begin
        done_count++;
        if (o_S_vld) done_with_vld++;
      end
    end
  end

  task automatic run_op(input logic sub, input logic cin, input int gap, input logic inject);
    got_words.delete();
    done_count    = 0;
    done_with_vld = 0;
    @(posedge clk); #1;
    i_start = 1'b1; i_sub = sub; i_Cin = cin;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      i_vld = 1'b1; i_A = opa[w]; i_B = opb[w]; i_start = inject;
      @(posedge clk); #1;
      i_vld = 1'b0; i_start = 1'b0; i_A = '0; i_B = '0;
      if (w < 3) for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
    for (int k = 0; k < 8 && done_count == 0; k++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({o_rdy, o_S, o_S_vld, o_Cout, o_ovf, o_busy, o_done} !== 37'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_idle outs=%h expected 0", {o_rdy, o_S, o_S_vld, o_Cout, o_ovf, o_busy, o_done});
    end
    @(posedge clk); #1;
    i_start = 1'b1; i_sub = 1'b0; i_Cin = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0; i_vld = 1'b1; i_A = 32'd5; i_B = 32'd0;
    @(posedge clk); #1;
    i_vld = 1'b0;
    n_cmp++;
    if (o_S !== 32'd5 || o_S_vld !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL pre_reset_word got=%h vld=%b expected 00000005 vld=1", o_S, o_S_vld);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_rdy, o_S, o_S_vld, o_Cout, o_ovf, o_busy, o_done} !== 37'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_async outs=%h expected 0", {o_rdy, o_S, o_S_vld, o_Cout, o_ovf, o_busy, o_done});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_busy got=%b expected 0", o_busy);
    end
  endtask

  task automatic test_add_ripple(input int gap, input string tag);
    for (int w = 0; w < 4; w++) begin
      opa[w] = 32'hFFFF_FFFF; opb[w] = '0; exp_w[w] = '0;
    end
    opb[0] = 32'h1;
    run_op(1'b0, 1'b0, gap, 1'b0);
    n_cmp++;
    if (got_words.size() !== 4) begin
      n_bad++;
      $display("[TB] FAIL %s_count got=%0d expected 4", tag, got_words.size());
    end
    for (int w = 0; w < 4 && w < got_words.size(); w++) begin
      n_cmp++;
      if (got_words[w] !== exp_w[w]) begin
        n_bad++;
        $display("[TB] FAIL %s_word%0d got=%h expected %h", tag, w, got_words[w], exp_w[w]);
      end
    end
    n_cmp++;
    if (o_Cout !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL %s_cout got=%b expected 1", tag, o_Cout);
    end
    n_cmp++;
    if (done_count !== 1 || done_with_vld !== 1) begin
      n_bad++;
      $display("[TB] FAIL %s_done got=%0d/%0d expected 1/1", tag, done_count, done_with_vld);
    end
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL %s_idle busy=%b expected 0", tag, o_busy);
    end
  endtask

  task automatic test_sub();
    for (int w = 0; w < 4; w++) begin
      opa[w] = '0; opb[w] = '0; exp_w[w] = 32'hFFFF_FFFF;
    end
    opb[0] = 32'h1;
    run_op(1'b1, 1'b1, 0, 1'b0);
    n_cmp++;
    if (got_words.size() !== 4) begin
      n_bad++;
      $display("[TB] FAIL sub_count got=%0d expected 4", got_words.size());
    end
    for (int w = 0; w < 4 && w < got_words.size(); w++) begin
      n_cmp++;
      if (got_words[w] !== exp_w[w]) begin
        n_bad++;
        $display("[TB] FAIL sub_word%0d got=%h expected %h", w, got_words[w], exp_w[w]);
      end
    end
    n_cmp++;
    if (o_Cout !== 1'b0 || done_count !== 1) begin
      n_bad++;
      $display("[TB] FAIL sub_cout_done got=%b/%0d expected 0/1", o_Cout, done_count);
    end
  endtask

  task automatic test_abort_restart();
    got_words.delete();
    done_count = 0;
    @(posedge clk); #1;
    i_start = 1'b1; i_sub = 1'b0; i_Cin = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int w = 0; w < 2; w++) begin
      i_vld = 1'b1; i_A = 32'h10 + w; i_B = 32'h1;
      @(posedge clk); #1;
    end
    i_vld = 1'b0;
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done_count !== 0 || o_busy !== 1'b0 || o_rdy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL abort_state done=%0d busy=%b rdy=%b expected 0/0/0", done_count, o_busy, o_rdy);
    end
    for (int w = 0; w < 4; w++) begin
      opa[w] = 32'h1; opb[w] = 32'h2; exp_w[w] = 32'h3;
    end
    exp_w[0] = 32'h4;
    run_op(1'b0, 1'b1, 1, 1'b1);
    n_cmp++;
    if (got_words.size() !== 4) begin
      n_bad++;
      $display("[TB] FAIL restart_count got=%0d expected 4", got_words.size());
    end
    for (int w = 0; w < 4 && w < got_words.size(); w++) begin
      n_cmp++;
      if (got_words[w] !== exp_w[w]) begin
        n_bad++;
        $display("[TB] FAIL restart_word%0d got=%h expected %h", w, got_words[w], exp_w[w]);
      end
    end
    n_cmp++;
    if (o_Cout !== 1'b0 || done_count !== 1 || o_busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL restart_end cout=%b done=%0d busy=%b expected 0/1/0", o_Cout, done_count, o_busy);
    end
  endtask

  task automatic test_ovf();
    logic exp_ovf;
`ifdef ADDER_MW_SEQ_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    for (int w = 0; w < 4; w++) begin
      opa[w] = '0; opb[w] = '0; exp_w[w] = '0;
    end
    opa[3] = 32'h7FFF_FFFF; opb[3] = 32'h1; exp_w[3] = 32'h8000_0000;
    run_op(1'b0, 1'b0, 0, 1'b0);
    n_cmp++;
    if (got_words.size() !== 4 || got_words[3] !== exp_w[3]) begin
      n_bad++;
      $display("[TB] FAIL ovf_top_word count=%0d expected 4 top=%h expected %h",
               got_words.size(), (got_words.size() == 4) ? got_words[3] : 32'hx, exp_w[3]);
    end
    n_cmp++;
    if (o_ovf !== exp_ovf || o_Cout !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL ovf_flag ovf=%b cout=%b expected %b/0", o_ovf, o_Cout, exp_ovf);
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_sub = 1'b0; i_Cin = 1'b0;
    i_vld = 1'b0; i_A = '0; i_B = '0;
    done_count = 0; done_with_vld = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    test_reset();
    test_add_ripple(0, "add");
    test_sub();
    test_add_ripple(3, "stall");
    test_abort_restart();
    test_ovf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
